mips32_pipe_core: RTL and testbench

//  5-stage in-order MIPS32-subset core (IF,ID,EX,MEM,WB) on one clock, with unified internal word memory.
//  32x32 register file; R0 hardwired to 0. No hazard interlocks: software pads data hazards with NOPs.
//  Top-level compute block; a debug port loads programs and inspects state.

---
 rtl/mips32_pkg.sv | 83 ++++++++
 rtl/mips32_alu.sv | 26 ++
 rtl/mips32_pipe_core.sv | 139 +++++++++++++
 tb/tb_mips32_pipe_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared encodings, instruction classes and pipeline-register layouts for the MIPS32-subset core.
// MUL decode depends on the MIPS32_MUL_EN macro.
package mips32_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned IMM_W = 16;

  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_AND   = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR    = 6'b000011;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b000100;
  localparam logic [OP_W-1:0] OP_MUL   = 6'b000101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b001000;
  localparam logic [OP_W-1:0] OP_SW    = 6'b001001;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_SUBI  = 6'b001011;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_BNEQZ = 6'b001101;
  localparam logic [OP_W-1:0] OP_BEQZ  = 6'b001110;
  localparam logic [OP_W-1:0] OP_HLT   = 6'b111111;

  // Undefined opcode 110000: decodes as NOP and never writes state.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'hC000_0000;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} instr_type_e;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] npc;
  } if_id_t;

  typedef struct packed {
    instr_type_e      itype;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] dst;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  npc;
  } id_ex_t;

  typedef struct packed {
    instr_type_e      itype;
    logic [REG_W-1:0] dst;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  b;
  } ex_mem_t;

  typedef struct packed {
    instr_type_e      itype;
    logic [REG_W-1:0] dst;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  lmd;
  } mem_wb_t;

  localparam if_id_t  IF_ID_NOP  = '{ir: NOP_INSTR, default: '0};
  localparam id_ex_t  ID_EX_NOP  = '{itype: NOP, default: '0};
  localparam ex_mem_t EX_MEM_NOP = '{itype: NOP, default: '0};
  localparam mem_wb_t MEM_WB_NOP = '{itype: NOP, default: '0};

  function automatic instr_type_e decode_type(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: decode_type = RR_ALU;
`ifdef MIPS32_MUL_EN
      OP_MUL:                                decode_type = RR_ALU;
`endif
      OP_ADDI, OP_SUBI, OP_SLTI:             decode_type = RM_ALU;
      OP_LW:                                 decode_type = LOAD;
      OP_SW:                                 decode_type = STORE;
      OP_BNEQZ, OP_BEQZ:                     decode_type = BRANCH;
      OP_HLT:                                decode_type = HALT;
      default:                               decode_type = NOP;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    sext_imm = {{(XLEN - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for the MIPS32-subset core; MUL exists only when MIPS32_MUL_EN is defined.
module mips32_alu
  import mips32_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  // Default add also serves LW/SW address generation.
  always_comb begin
    y_o = a_i + b_i;
    case (op_i)
      OP_SUB, OP_SUBI: y_o = a_i - b_i;
      OP_AND:          y_o = a_i & b_i;
      OP_OR:           y_o = a_i | b_i;
      OP_SLT, OP_SLTI: y_o = {{(XLEN - 1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef MIPS32_MUL_EN
      OP_MUL:          y_o = a_i * b_i;
`endif
      default:         ;
    endcase
  end

endmodule

// File: rtl/mips32_pipe_core.sv
// Five-stage MIPS32-subset pipeline with unified word memory and a debug load/inspect port.
// Optional multiplier selected by MIPS32_MUL_EN.
module mips32_pipe_core
  import mips32_pkg::*;
#(
  parameter int unsigned MEM_WORDS     = 1024,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dbg_we,
  input  logic            dbg_sel,
  input  logic [9:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            halted
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [XLEN-1:0] mem [MEM_WORDS];
  logic [XLEN-1:0] rf  [32];

  logic [XLEN-1:0] pc_q, pc_d;
  logic            halting_q, halting_d, halted_q, halted_d;
  if_id_t          id_q, id_d;
  id_ex_t          ex_q, ex_d;
  ex_mem_t         mem_q, mem_d;
  mem_wb_t         wb_q, wb_d;

  logic [OP_W-1:0]  id_op;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  instr_type_e      id_type;
  logic [XLEN-1:0]  rs_val, rt_val, alu_b, alu_y, wb_val;
  logic             wb_we, br_taken, store_we;

  assign id_op   = id_q.ir[31:26];
  assign id_rs   = id_q.ir[25:21];
  assign id_rt   = id_q.ir[20:16];
  assign id_rd   = id_q.ir[15:11];
  assign id_type = decode_type(id_op);

  assign wb_we  = (wb_q.itype inside {RR_ALU, RM_ALU, LOAD}) && (wb_q.dst != '0) && !halted_q;
  assign wb_val = (wb_q.itype == LOAD) ? wb_q.lmd : wb_q.alu;

  // Write-through: a register retiring this cycle is visible to the instruction in ID.
  assign rs_val = (id_rs == '0) ? '0 : (wb_we && wb_q.dst == id_rs) ? wb_val : rf[id_rs];
  assign rt_val = (id_rt == '0) ? '0 : (wb_we && wb_q.dst == id_rt) ? wb_val : rf[id_rt];

  assign alu_b = (ex_q.itype == RR_ALU) ? ex_q.b : ex_q.imm;

  mips32_alu u_alu (
    .op_i (ex_q.op),
    .a_i  (ex_q.a),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  // BEQZ takes when rs==0, BNEQZ when rs!=0.
  assign br_taken = (ex_q.itype == BRANCH) && ((ex_q.op == OP_BEQZ) == (ex_q.a == '0));

  always_comb begin
    pc_d      = pc_q + 1;
    id_d.ir   = mem[pc_q[AW-1:0]];
    id_d.npc  = pc_q + 1;
    halting_d = halting_q | ((id_type == HALT) && !br_taken);
    if (br_taken) begin
      pc_d    = ex_q.npc + ex_q.imm;
      id_d.ir = NOP_INSTR;
    end else if ((id_type == HALT) || halting_q) begin
      pc_d    = pc_q;
      id_d.ir = NOP_INSTR;
    end

    ex_d = ID_EX_NOP;
    if (!br_taken) begin
      ex_d.itype = id_type;
      ex_d.op    = id_op;
      ex_d.dst   = (id_type == RR_ALU) ? id_rd : id_rt;
      ex_d.a     = rs_val;
      ex_d.b     = rt_val;
      ex_d.imm   = sext_imm(id_q.ir[IMM_W-1:0]);
      ex_d.npc   = id_q.npc;
    end

    mem_d.itype = ex_q.itype;
    mem_d.dst   = ex_q.dst;
    mem_d.alu   = alu_y;
    mem_d.b     = ex_q.b;

    wb_d.itype = mem_q.itype;
    wb_d.dst   = mem_q.dst;
    wb_d.alu   = mem_q.alu;
    wb_d.lmd   = mem[mem_q.alu[AW-1:0]];

    halted_d = halted_q | (wb_q.itype == HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      halting_q <= 1'b0;
      halted_q  <= 1'b0;
      id_q      <= IF_ID_NOP;
      ex_q      <= ID_EX_NOP;
      mem_q     <= EX_MEM_NOP;
      wb_q      <= MEM_WB_NOP;
    end else if (!halted_q) begin
      pc_q      <= pc_d;
      halting_q <= halting_d;
      halted_q  <= halted_d;
      id_q      <= id_d;
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
    end
  end

  assign store_we = (mem_q.itype == STORE) && !halted_q;

  // Debug writes come last so they win over a core write to the same word.
  always_ff @(posedge clk) begin
    if (store_we) mem[mem_q.alu[AW-1:0]] <= mem_q.b;
    if (dbg_we && !dbg_sel) mem[dbg_addr[AW-1:0]] <= dbg_wdata;
  end

  always_ff @(posedge clk) begin
    if (wb_we) rf[wb_q.dst] <= wb_val;
    if (dbg_we && dbg_sel) rf[dbg_addr[4:0]] <= dbg_wdata;
  end

  always_comb begin
    dbg_rdata = mem[dbg_addr[AW-1:0]];
    if (dbg_sel) dbg_rdata = (dbg_addr[4:0] == '0) ? '0 : rf[dbg_addr[4:0]];
  end

  assign halted = halted_q;

endmodule

// File: tb/tb_mips32_pipe_core.sv
// Directed scoreboard bench for mips32_pipe_core; expectations follow MIPS32_MUL_EN.
module tb_mips32_pipe_core;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        dbg_we    = 1'b0;
  logic        dbg_sel   = 1'b0;
  logic [9:0]  dbg_addr  = '0;
  logic [31:0] dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic        halted;

  localparam logic [31:0] NOP = 32'hC000_0000;

  mips32_pipe_core #(
    .MEM_WORDS     (1024),
    .MEM_INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dbg_we    (dbg_we),
    .dbg_sel   (dbg_sel),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        sel;
    logic [9:0]  addr;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dbg_write(input logic sel, input logic [9:0] addr, input logic [31:0] data);
    dbg_we    = 1'b1;
    dbg_sel   = sel;
    dbg_addr  = addr;
    dbg_wdata = data;
    @(posedge clk);
    #1;
    dbg_we = 1'b0;
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    dbg_write(1'b1, 10'(idx), v);
  endtask

  task automatic set_mem(input int a, input logic [31:0] v);
    dbg_write(1'b0, 10'(a), v);
  endtask

  task automatic exp_reg(input int idx, input logic [31:0] v);
    exp_t e;
    e.tag  = $sformatf("R%0d", idx);
    e.sel  = 1'b1;
    e.addr = 10'(idx);
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic exp_mem(input int a, input logic [31:0] v);
    exp_t e;
    e.tag  = $sformatf("M%0d", a);
    e.sel  = 1'b0;
    e.addr = 10'(a);
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drain(input string test);
    exp_t e;
    while (sb.size() > 0) begin
      e        = sb.pop_front();
      dbg_sel  = e.sel;
      dbg_addr = e.addr;
      #1;
      check({test, ".", e.tag}, dbg_rdata, e.exp);
    end
  endtask

  // Hold reset and blank the program area so earlier programs cannot leak in.
  task automatic begin_test();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) set_mem(i, NOP);
  endtask

  task automatic run(input int cycles);
    rst_n = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset.halted", {31'b0, halted}, 32'd0);

    // RR / RM arithmetic, signed compares, undefined opcode
    begin_test();
    set_reg(2, 32'd6);
    set_reg(3, 32'd4);
    set_reg(9, 32'hDEAD_BEEF);
    set_reg(13, 32'h0000_AAAA);
    set_reg(18, 32'd0);
    set_reg(19, -32'sd5);
    set_reg(25, 32'h0000_5A5A);
    set_mem(0, 32'h0043_2800);   // ADD  R5,R2,R3
    set_mem(1, 32'h0443_3800);   // SUB  R7,R2,R3
    set_mem(2, 32'h1443_4800);   // MUL  R9,R2,R3
    set_mem(3, 32'h284B_0003);   // ADDI R11,R2,3
    set_mem(4, 32'h304D_0003);   // SLTI R13,R2,3
    set_mem(5, 32'h0843_7000);   // AND  R14,R2,R3
    set_mem(6, 32'h0C43_7800);   // OR   R15,R2,R3
    set_mem(7, 32'h1062_8000);   // SLT  R16,R3,R2
    set_mem(8, 32'h2C71_0005);   // SUBI R17,R3,5
    set_mem(9, 32'h3272_0000);   // SLTI R18,R19,0
    set_mem(10, 32'h1C43_C800);  // undefined op targeting R25
    exp_reg(5, 32'd10);
    exp_reg(7, 32'd2);
`ifdef MIPS32_MUL_EN
    exp_reg(9, 32'd24);
`else
    exp_reg(9, 32'hDEAD_BEEF);
`endif
    exp_reg(11, 32'd9);
    exp_reg(13, 32'd0);
    exp_reg(14, 32'd4);
    exp_reg(15, 32'd6);
    exp_reg(16, 32'd1);
    exp_reg(17, 32'hFFFF_FFFF);
    exp_reg(18, 32'd1);
    exp_reg(25, 32'h0000_5A5A);
    run(40);
    check("alu.halted", {31'b0, halted}, 32'd0);
    drain("alu");

    // Load/store, R0 immunity, load-use spacing
    begin_test();
    set_reg(1, 32'd100);
    set_reg(2, 32'd6);
    set_reg(4, 32'd0);
    set_reg(0, 32'h55);
    set_mem(104, 32'd0);
    set_mem(0, 32'h2422_0004);   // SW   R2,4(R1)
    set_mem(3, 32'h2024_0004);   // LW   R4,4(R1)
    set_mem(4, 32'h2800_0009);   // ADDI R0,R0,9
    set_mem(6, 32'h0084_D800);   // ADD  R27,R4,R4
    set_mem(7, 32'h281A_0001);   // ADDI R26,R0,1
    exp_mem(104, 32'd6);
    exp_reg(4, 32'd6);
    exp_reg(0, 32'd0);
    exp_reg(27, 32'd12);
    exp_reg(26, 32'd1);
    run(40);
    drain("ldst");

    // Branch loop with shadow slots, then forward BEQZ
    begin_test();
    set_reg(1, 32'd3);
    set_reg(6, 32'd0);
    set_reg(20, 32'd0);
    set_reg(21, 32'd0);
    set_reg(22, 32'd0);
    set_mem(0, 32'h2821_FFFF);   // ADDI  R1,R1,-1
    set_mem(3, 32'h3420_FFFC);   // BNEQZ R1,-4
    set_mem(4, 32'h2A94_0001);   // ADDI  R20,R20,1 (shadow)
    set_mem(5, 32'h2806_0007);   // ADDI  R6,R0,7
    set_mem(6, 32'h3800_0002);   // BEQZ  R0,+2
    set_mem(7, 32'h2815_0001);   // ADDI  R21,R0,1 (shadow)
    set_mem(8, 32'h2815_0001);   // ADDI  R21,R0,1 (shadow)
    set_mem(9, 32'h2816_0003);   // ADDI  R22,R0,3
    exp_reg(1, 32'd0);
    exp_reg(6, 32'd7);
    exp_reg(20, 32'd1);
    exp_reg(21, 32'd0);
    exp_reg(22, 32'd3);
    run(40);
    drain("branch");

    // Halt: drain of older work, exact halt edge, freeze, async reset
    begin_test();
    set_reg(8, 32'h0000_1234);
    set_reg(23, 32'd0);
    set_mem(0, 32'h2817_0009);   // ADDI R23,R0,9
    set_mem(1, 32'hFC00_0000);   // HLT
    set_mem(2, 32'h2808_0005);   // ADDI R8,R0,5
    run(5);
    check("halt.edge5", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #1;
    check("halt.edge6", {31'b0, halted}, 32'd1);
    run(34);
    exp_reg(8, 32'h0000_1234);
    exp_reg(23, 32'd9);
    drain("halt");
    repeat (20) @(posedge clk);
    #1;
    check("halt.stable", {31'b0, halted}, 32'd1);
    exp_reg(8, 32'h0000_1234);
    exp_reg(23, 32'd9);
    exp_mem(2, 32'h2808_0005);
    drain("frozen");

    #2 rst_n = 1'b0;
    #1;
    check("midreset.halted", {31'b0, halted}, 32'd0);
    set_reg(23, 32'd0);
    run(40);
    check("rerun.halted", {31'b0, halted}, 32'd1);
    exp_reg(23, 32'd9);
    exp_reg(8, 32'h0000_1234);
    drain("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
